nonce_search_ctrl: RTL and testbench

//  Nonce-iteration engine between the miner slave register file and the SHA-256d hash core.
//  On start it latches the 608-bit header (76 bytes) and the 256-bit target.
//  It issues {header, nonce} blocks to the hash core one at a time and compares each

---
 rtl/nonce_search_ctrl.sv | 106 ++++++++++
 tb/tb_nonce_search_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: feeds {header, nonce} blocks to a SHA-256d core
// and stops on the first digest below the target or when the nonce range is exhausted.
module nonce_search_ctrl #(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_LAST  = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [607:0] msgHeader,
    input  logic [255:0] target,
    output logic         shaStart,
    output logic [639:0] shaBlock,
    input  logic         shaDone,
    input  logic [255:0] shaDigest,
    output logic [1:0]   status,
    output logic [31:0]  nonce,
    output logic [31:0]  hashCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_FOUND = 3'd4;
    localparam logic [2:0] S_EXH   = 3'd5;

    logic [2:0]   r_state;
    logic [607:0] r_header;
    logic [255:0] r_target;
    logic [255:0] r_digest;
    logic [31:0]  r_nonce;
    logic [31:0]  r_count;

    logic w_stopped;
    logic w_start_ok;
    logic w_abort_ok;
    logic w_hit;

    assign w_stopped  = (r_state == S_IDLE) || (r_state == S_FOUND) || (r_state == S_EXH);
    assign w_abort_ok = abort && (r_state != S_IDLE);
    assign w_start_ok = start && !abort && w_stopped;
    assign w_hit      = r_digest < r_target;

    // Search state machine, latched operands and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_header <= '0;
            r_target <= '0;
            r_digest <= '0;
            r_nonce  <= '0;
            r_count  <= '0;
        end else if (w_abort_ok) begin
            r_state <= S_IDLE;
        end else if (w_start_ok) begin
            r_header <= msgHeader;
            r_target <= target;
            r_nonce  <= NONCE_START;
            r_count  <= '0;
            r_state  <= S_ISSUE;
        end else begin
            case (r_state)
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (shaDone) begin
                        r_digest <= shaDigest;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (r_count != 32'hFFFF_FFFF) begin
                        r_count <= r_count + 32'd1;
                    end
                    if (w_hit) begin
                        r_state <= S_FOUND;
                    end else if (r_nonce == NONCE_LAST) begin
                        r_state <= S_EXH;
                    end else begin
                        r_nonce <= r_nonce + 32'd1;
                        r_state <= S_ISSUE;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // Status code decoded from the current state
    always_comb begin
        status = 2'd0;
        case (r_state)
            S_ISSUE, S_WAIT, S_CMP: status = 2'd1;
            S_FOUND:                status = 2'd3;
            S_EXH:                  status = 2'd2;
            default:                status = 2'd0;
        endcase
    end

    assign shaStart  = (r_state == S_ISSUE) && !abort;
    assign shaBlock  = {r_header, r_nonce};
    assign nonce     = r_nonce;
    assign hashCount = r_count;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: three parameterisations share one
// behavioural hash model that answers 64 cycles after each request.
module tb_nonce_search_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [607:0] hdr;
    logic [255:0] tgt;
    logic [2:0]   start_v;
    logic [2:0]   abort_v;
    logic [2:0]   sha_start_v;
    logic [2:0]   sha_done_v;
    logic [639:0] blk_v    [3];
    logic [255:0] digest_v [3];
    logic [1:0]   status_v [3];
    logic [31:0]  nonce_v  [3];
    logic [31:0]  count_v  [3];

    int mode   [3];
    int pulses [3];
    int dly    [3];
    logic [31:0] req_nonce [3];

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] T_HIT = 256'h1 << 252;
    localparam logic [255:0] T_EQ  = 256'h1 << 200;
    localparam logic [255:0] D_LOW = {4'h0, {252{1'b1}}};
    localparam logic [607:0] H1 = {19{32'hA5A5_0001}};
    localparam logic [607:0] H2 = {19{32'h5A5A_0002}};
    localparam logic [607:0] H3 = {19{32'h3C3C_0003}};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam logic [31:0] NS = (g == 1) ? 32'hFFFF_FFFE : 32'h0;
        localparam logic [31:0] NL = (g == 2) ? 32'h3 : 32'hFFFF_FFFF;
        nonce_search_ctrl #(.NONCE_START(NS), .NONCE_LAST(NL)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[g]),
            .abort     (abort_v[g]),
            .msgHeader (hdr),
            .target    (tgt),
            .shaStart  (sha_start_v[g]),
            .shaBlock  (blk_v[g]),
            .shaDone   (sha_done_v[g]),
            .shaDigest (digest_v[g]),
            .status    (status_v[g]),
            .nonce     (nonce_v[g]),
            .hashCount (count_v[g])
        );
    end

    function automatic logic [255:0] dig(int m, logic [31:0] n);
        case (m)
            0:       return (n == 32'd5) ? D_LOW : '1;
            2:       return T_EQ;
            default: return '1;
        endcase
    endfunction

    // Behavioural hash core: done pulse 64 cycles after each request
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            sha_done_v[i] <= 1'b0;
            if (sha_start_v[i]) begin
                pulses[i]    <= pulses[i] + 1;
                dly[i]       <= 64;
                req_nonce[i] <= blk_v[i][31:0];
            end else if (dly[i] != 0) begin
                dly[i] <= dly[i] - 1;
                if (dly[i] == 1) begin
                    sha_done_v[i] <= 1'b1;
                    digest_v[i]   <= dig(mode[i], req_nonce[i]);
                end
            end
        end
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(int d);
        start_v[d] = 1'b1;
        tick(1);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_stop(int d, string tag);
        int k;
        k = 0;
        while (status_v[d] == 2'd1 && k < 3000) begin
            tick(1);
            k++;
        end
        check({tag, "_timeout"}, 64'(k < 3000), 64'd1);
    endtask

    task automatic wait_nonce(int d, logic [31:0] n, string tag);
        int k;
        k = 0;
        while (nonce_v[d] != n && k < 3000) begin
            tick(1);
            k++;
        end
        check({tag, "_timeout"}, 64'(k < 3000), 64'd1);
    endtask

    initial begin
        int p;
        start_v = '0;
        abort_v = '0;
        hdr = '0;
        tgt = '0;
        for (int i = 0; i < 3; i++) begin
            mode[i] = 1;
            pulses[i] = 0;
            dly[i] = 0;
            req_nonce[i] = '0;
            digest_v[i] = '0;
        end
        tick(3);
        check("rst_status", 64'(status_v[0]), 64'd0);
        check("rst_shastart", 64'(sha_start_v[0]), 64'd0);
        check("rst_nonce", 64'(nonce_v[0]), 64'd0);
        check("rst_count", 64'(count_v[0]), 64'd0);
        rst = 1'b0;
        tick(2);

        // T2: hit at nonce 5
        mode[0] = 0;
        tgt = T_HIT;
        hdr = H1;
        p = pulses[0];
        pulse_start(0);
        check("t2_latency", 64'(sha_start_v[0]), 64'd1);
        hdr = H3;
        wait_stop(0, "t2");
        check("t2_status", 64'(status_v[0]), 64'd3);
        check("t2_nonce", 64'(nonce_v[0]), 64'd5);
        check("t2_count", 64'(count_v[0]), 64'd6);
        check("t2_pulses", 64'(pulses[0] - p), 64'd6);
        check("t2_header", 64'(blk_v[0][639:32] == H1), 64'd1);
        check("t2_blk_nonce", 64'(blk_v[0][31:0]), 64'd5);

        // T3: exhaust over a two-nonce range at the top of the space
        tgt = T_HIT;
        hdr = H1;
        p = pulses[1];
        pulse_start(1);
        wait_stop(1, "t3");
        check("t3_status", 64'(status_v[1]), 64'd2);
        check("t3_nonce", 64'(nonce_v[1]), 64'hFFFF_FFFF);
        check("t3_count", 64'(count_v[1]), 64'd2);
        tick(150);
        check("t3_pulses", 64'(pulses[1] - p), 64'd2);
        check("t3_hold", 64'(status_v[1]), 64'd2);

        // T4: digest equal to target is never a hit
        mode[2] = 2;
        tgt = T_EQ;
        pulse_start(2);
        wait_stop(2, "t4");
        check("t4_status", 64'(status_v[2]), 64'd2);
        check("t4_count", 64'(count_v[2]), 64'd4);
        check("t4_nonce", 64'(nonce_v[2]), 64'd3);

        // T5: abort during WAIT of nonce 2, late done ignored
        mode[0] = 1;
        tgt = T_HIT;
        pulse_start(0);
        wait_nonce(0, 32'd2, "t5");
        tick(10);
        abort_v[0] = 1'b1;
        check("t5_abort_shastart", 64'(sha_start_v[0]), 64'd0);
        tick(1);
        abort_v[0] = 1'b0;
        check("t5_status", 64'(status_v[0]), 64'd0);
        tick(100);
        check("t5_idle", 64'(status_v[0]), 64'd0);
        check("t5_count", 64'(count_v[0]), 64'd2);
        check("t5_nonce", 64'(nonce_v[0]), 64'd2);

        // T6: contention cases
        hdr = H2;
        pulse_start(0);
        tick(5);
        hdr = H3;
        pulse_start(0);
        tick(2);
        check("t6_busy", 64'(status_v[0]), 64'd1);
        check("t6_header", 64'(blk_v[0][639:32] == H2), 64'd1);
        start_v[0] = 1'b1;
        abort_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        abort_v[0] = 1'b0;
        check("t6_both", 64'(status_v[0]), 64'd0);
        tick(1);
        check("t6_both_hold", 64'(status_v[0]), 64'd0);
        mode[0] = 0;
        hdr = H2;
        pulse_start(0);
        wait_stop(0, "t6");
        check("t6_found", 64'(status_v[0]), 64'd3);
        pulse_start(0);
        check("t6_restart_count", 64'(count_v[0]), 64'd0);
        check("t6_restart_nonce", 64'(nonce_v[0]), 64'd0);
        check("t6_restart_start", 64'(sha_start_v[0]), 64'd1);

        // T1: reset in the middle of WAIT
        wait_nonce(0, 32'd3, "t1");
        tick(10);
        rst = 1'b1;
        #1;
        check("t1_status", 64'(status_v[0]), 64'd0);
        check("t1_shastart", 64'(sha_start_v[0]), 64'd0);
        check("t1_nonce", 64'(nonce_v[0]), 64'd0);
        check("t1_count", 64'(count_v[0]), 64'd0);
        tick(2);
        rst = 1'b0;
        p = pulses[0];
        tick(100);
        check("t1_no_req", 64'(pulses[0] - p), 64'd0);
        check("t1_idle", 64'(status_v[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
